// File: rtl/enemy_hit_tracker_if.sv
// Draw-request / strobe bundle between the enemy stock manager side and the
// hit tracker. The master drives pixel requests and frame control, the slave
// (the tracker) returns collision strobes and game status.
interface enemy_hit_tracker_if #(
   parameter int AMOUNT_OF_ENEMIES = 2
);
   logic                         startOfFrame;
   logic                         pause;
   logic                         enemyDrawReq;
   logic                         headsUpDrawReq;
   logic [3:0]                   drawingRequestorId;
   logic                         bulletDrawReq;
   logic [2:0]                   shotCollision;
   logic                         dodgeBullet;
   logic                         bulletConsumed;
   logic [AMOUNT_OF_ENEMIES-1:0] aliveMask;
   logic [15:0]                  score;
   logic [3:0]                   levelNum;
   logic                         newLevel;

   modport master (
      output startOfFrame, pause, enemyDrawReq, headsUpDrawReq,
             drawingRequestorId, bulletDrawReq,
      input  shotCollision, dodgeBullet, bulletConsumed, aliveMask,
             score, levelNum, newLevel
   );

   modport slave (
      input  startOfFrame, pause, enemyDrawReq, headsUpDrawReq,
             drawingRequestorId, bulletDrawReq,
      output shotCollision, dodgeBullet, bulletConsumed, aliveMask,
             score, levelNum, newLevel
   );
endinterface

// File: rtl/enemy_hit_tracker.sv
// Enemy hit tracker: turns bullet/enemy pixel overlap into hit and dodge
// strobes (Mealy, so the stock manager can route them by its current id),
// and keeps per-enemy health, the alive mask, the score and the level FSM.
module enemy_hit_tracker #(
   parameter int AMOUNT_OF_ENEMIES  = 2,
   parameter int ENEMY_HITS         = 3,
   parameter int SCORE_PER_KILL     = 10,
   parameter int CLEAR_DELAY_FRAMES = 60
) (
   input  logic               clk,
   input  logic               reset,
   enemy_hit_tracker_if.slave bus
);
   localparam int N  = AMOUNT_OF_ENEMIES;
   localparam int HW = $clog2(ENEMY_HITS + 1);
   localparam int CW = (CLEAR_DELAY_FRAMES > 1) ? $clog2(CLEAR_DELAY_FRAMES) : 1;
   localparam logic [HW-1:0] FULL_HEALTH = HW'(ENEMY_HITS);
   localparam logic [CW-1:0] LAST_FRAME  = CW'(CLEAR_DELAY_FRAMES - 1);

   typedef enum logic [1:0] {PLAY = 2'd0, CLEARED = 2'd1, NEWLVL = 2'd2} levelStateT;

   levelStateT    state, nextState;
   logic [HW-1:0] health [N];
   logic [N-1:0]  aliveMask, hitFlag, dodgeFlag, selOneHot;
   logic [15:0]   score;
   logic [3:0]    levelNum;
   logic [CW-1:0] frameCnt;
   logic          bulletConsumed, newLevel;
   logic          selValid, selAlive, selHitFlag, selDodgeFlag;
   logic [HW-1:0] selHealth;
   logic          armed, hitCond, dodgeCond, killCond;

   function automatic logic [15:0] satAddScore(input logic [15:0] s);
      logic [16:0] sum;
      sum = {1'b0, s} + 17'(SCORE_PER_KILL);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   function automatic logic [3:0] satIncLevel(input logic [3:0] l);
      return (l == 4'hF) ? l : l + 4'd1;
   endfunction

   // Pick the requesting enemy's state; an out-of-range id matches nothing.
   // A startOfFrame cycle already belongs to the new frame, so the flags read as clear.
   always_comb begin
      selValid     = 1'b0;
      selAlive     = 1'b0;
      selHitFlag   = 1'b0;
      selDodgeFlag = 1'b0;
      selHealth    = '0;
      selOneHot    = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.drawingRequestorId == 4'(i)) begin
            selValid     = 1'b1;
            selOneHot[i] = 1'b1;
            selAlive     = aliveMask[i];
            selHitFlag   = hitFlag[i] & ~bus.startOfFrame;
            selDodgeFlag = dodgeFlag[i] & ~bus.startOfFrame;
            selHealth    = health[i];
         end
      end
   end

   // Same-cycle hit / kill / dodge conditions for the pixel being drawn.
   always_comb begin
      armed     = (state == PLAY) & ~bus.pause & bus.bulletDrawReq & selValid & selAlive;
      hitCond   = armed & bus.enemyDrawReq & ~selHitFlag;
      dodgeCond = armed & bus.headsUpDrawReq & ~selDodgeFlag;
      killCond  = hitCond & (selHealth == HW'(1));
   end

   assign bus.shotCollision  = {1'b0, killCond, hitCond};
   assign bus.dodgeBullet    = dodgeCond;
   assign bus.bulletConsumed = bulletConsumed;
   assign bus.aliveMask      = aliveMask;
   assign bus.score          = score;
   assign bus.levelNum       = levelNum;
   assign bus.newLevel       = newLevel;

   // Level FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= PLAY;
      else       state <= nextState;
   end

   // Level FSM transitions: wipe-out -> delay in CLEARED -> one NEWLVL cycle.
   always_comb begin
      nextState = state;
      case (state)
         PLAY:    if (aliveMask == '0) nextState = CLEARED;
         CLEARED: if (bus.startOfFrame && !bus.pause && frameCnt == LAST_FRAME) nextState = NEWLVL;
         NEWLVL:  nextState = PLAY;
         default: nextState = PLAY;
      endcase
   end

   // Level FSM outputs.
   always_comb begin
      newLevel = (state == NEWLVL);
   end

   // Frames spent in CLEARED; held at zero while playing so CLEARED starts from 0.
   always_ff @(posedge clk) begin
      if (reset || state == PLAY)
         frameCnt <= '0;
      else if (state == CLEARED && bus.startOfFrame && !bus.pause)
         frameCnt <= frameCnt + CW'(1);
   end

   // Per-enemy health, alive mask, per-frame flags, score and level number.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) health[i] <= FULL_HEALTH;
         aliveMask      <= '1;
         hitFlag        <= '0;
         dodgeFlag      <= '0;
         score          <= 16'd0;
         levelNum       <= 4'd0;
         bulletConsumed <= 1'b0;
      end else begin
         bulletConsumed <= hitCond;
         if (newLevel) begin
            for (int i = 0; i < N; i++) health[i] <= FULL_HEALTH;
            aliveMask <= '1;
            hitFlag   <= '0;
            dodgeFlag <= '0;
            levelNum  <= satIncLevel(levelNum);
         end else begin
            hitFlag   <= (bus.startOfFrame ? '0 : hitFlag)   | (hitCond   ? selOneHot : '0);
            dodgeFlag <= (bus.startOfFrame ? '0 : dodgeFlag) | (dodgeCond ? selOneHot : '0);
            for (int i = 0; i < N; i++)
               if (hitCond && selOneHot[i]) health[i] <= health[i] - HW'(1);
            if (killCond) begin
               aliveMask <= aliveMask & ~selOneHot;
               score     <= satAddScore(score);
            end
         end
      end
   end
endmodule

// File: tb/tb_enemy_hit_tracker.sv
// Scoreboard bench for enemy_hit_tracker: the driver steps a game-level model
// each cycle and queues the outputs it expects; a negedge monitor compares.
module tb_enemy_hit_tracker;
   localparam int N     = 2;
   localparam int HITS  = 3;
   localparam int SPK   = 10;
   localparam int DELAY = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   enemy_hit_tracker_if #(.AMOUNT_OF_ENEMIES(N)) bus ();

   enemy_hit_tracker #(
      .AMOUNT_OF_ENEMIES(N), .ENEMY_HITS(HITS),
      .SCORE_PER_KILL(SPK), .CLEAR_DELAY_FRAMES(DELAY)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      logic [2:0]   sc;
      logic         dodge;
      logic         consumed;
      logic [N-1:0] alive;
      logic [15:0]  score;
      logic [3:0]   level;
      logic         newLevel;
   } expT;

   expT scoreQ[$];
   int  testsRun = 0;
   int  testsFailed = 0;

   // Game model: hits left per enemy (0 = dead), per-frame event memory,
   // score, level and the phase of the level (0 play, 1 cleared, 2 restart).
   int mHealth[N];
   bit mHitF[N];
   bit mDodgeF[N];
   int mScore, mLevel, mPhase, mFrames;
   bit mConsumed;

   task automatic mReset();
      for (int i = 0; i < N; i++) begin
         mHealth[i] = HITS; mHitF[i] = 0; mDodgeF[i] = 0;
      end
      mScore = 0; mLevel = 0; mPhase = 0; mFrames = 0; mConsumed = 0;
   endtask

   task automatic check(string nm, logic [31:0] act, logic [31:0] req);
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic drive(bit sof, bit pz, bit edr, bit hdr, int id, bit bdr, bit rst);
      expT e;
      bit  hit, dodge, kill, allDead;
      @(posedge clk);
      #1;
      reset                  = rst;
      bus.startOfFrame       = sof;
      bus.pause              = pz;
      bus.enemyDrawReq       = edr;
      bus.headsUpDrawReq     = hdr;
      bus.drawingRequestorId = 4'(id);
      bus.bulletDrawReq      = bdr;
      for (int i = 0; i < N; i++) e.alive[i] = (mHealth[i] > 0);
      e.score    = 16'(mScore);
      e.level    = 4'(mLevel);
      e.newLevel = (mPhase == 2);
      e.consumed = mConsumed;
      hit = 0; dodge = 0; kill = 0;
      if (mPhase == 0 && !pz && bdr && id < N) begin
         if (mHealth[id] > 0) begin
            hit   = edr && (sof || !mHitF[id]);
            dodge = hdr && (sof || !mDodgeF[id]);
            kill  = hit && (mHealth[id] == 1);
         end
      end
      e.sc    = {1'b0, kill, hit};
      e.dodge = dodge;
      scoreQ.push_back(e);
      if (rst) mReset();
      else begin
         allDead = 1;
         for (int i = 0; i < N; i++) if (mHealth[i] > 0) allDead = 0;
         mConsumed = hit;
         if (mPhase == 2) begin
            for (int i = 0; i < N; i++) begin
               mHealth[i] = HITS; mHitF[i] = 0; mDodgeF[i] = 0;
            end
            mLevel = (mLevel < 15) ? mLevel + 1 : 15;
            mPhase = 0;
         end else begin
            if (sof) for (int i = 0; i < N; i++) begin mHitF[i] = 0; mDodgeF[i] = 0; end
            if (hit) begin
               mHitF[id] = 1;
               mHealth[id]--;
               if (mHealth[id] == 0) mScore = (mScore + SPK > 65535) ? 65535 : mScore + SPK;
            end
            if (dodge) mDodgeF[id] = 1;
            if (mPhase == 0 && allDead) begin
               mPhase = 1; mFrames = 0;
            end else if (mPhase == 1 && sof && !pz) begin
               if (mFrames == DELAY - 1) mPhase = 2;
               else mFrames++;
            end
         end
      end
   endtask

   // mode 0 idle, 1 bullet over enemy body for 5 pixels, 2 bullet in heads-up zone
   task automatic frame(int len, int mode, int tid, bit pz);
      drive(1, pz, 0, 0, 0, 0, 0);
      for (int c = 0; c < len; c++) begin
         case (mode)
            1:       drive(0, pz, c < 5, 0, tid, c < 5, 0);
            2:       drive(0, pz, 0, c < 4, tid, c < 4, 0);
            default: drive(0, pz, 0, 0, tid, 0, 0);
         endcase
      end
   endtask

   task automatic rndCycle(bit sof);
      bit edr, hdr;
      edr = 1'($urandom_range(0, 1));
      hdr = !edr && ($urandom_range(0, 1) == 1);
      drive(sof, $urandom_range(0, 9) == 0, edr, hdr, int'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
   endtask

   // Monitor: one expected record per driven cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (scoreQ.size() > 0) begin
         expT e;
         e = scoreQ.pop_front();
         check("shotCollision",  32'(bus.shotCollision),  32'(e.sc));
         check("dodgeBullet",    32'(bus.dodgeBullet),    32'(e.dodge));
         check("bulletConsumed", 32'(bus.bulletConsumed), 32'(e.consumed));
         check("aliveMask",      32'(bus.aliveMask),      32'(e.alive));
         check("score",          32'(bus.score),          32'(e.score));
         check("levelNum",       32'(bus.levelNum),       32'(e.level));
         check("newLevel",       32'(bus.newLevel),       32'(e.newLevel));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.startOfFrame = 0; bus.pause = 0; bus.enemyDrawReq = 0;
      bus.headsUpDrawReq = 0; bus.drawingRequestorId = 4'd0; bus.bulletDrawReq = 0;
      repeat (2) @(posedge clk);
      mReset();
      // single hit per frame on enemy 0
      frame(8, 1, 0, 0);
      // heads-up dodges on enemy 0
      frame(8, 2, 0, 0);
      frame(8, 2, 0, 0);
      // kill enemy 1, then a hit on the dead enemy
      repeat (4) frame(8, 1, 1, 0);
      // paused hit attempt
      frame(8, 1, 0, 1);
      // finish enemy 0 -> CLEARED, with two paused frames in the delay
      frame(8, 1, 0, 0);
      frame(8, 1, 0, 0);
      frame(4, 0, 0, 0);
      frame(4, 0, 0, 1);
      frame(4, 0, 0, 1);
      frame(4, 0, 0, 0);
      frame(4, 0, 0, 0);
      frame(4, 0, 0, 0);
      // wipe out the second level, then reset in the middle of CLEARED
      repeat (3) frame(8, 1, 0, 0);
      repeat (3) frame(8, 1, 1, 0);
      frame(4, 0, 0, 0);
      drive(0, 0, 1, 0, 5, 1, 1);
      drive(0, 0, 1, 0, 5, 1, 0);
      drive(0, 0, 0, 1, 5, 1, 0);
      // randomized play
      for (int f = 0; f < 400; f++) begin
         rndCycle(1);
         repeat (6) rndCycle(0);
      end
      @(negedge clk);
      #1;
      check("queueDrained", 32'(scoreQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
